imm_ext_arbiter: RTL and testbench

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

---
 rtl/imm_ext_arbiter_if.sv | 54 +++++
 rtl/imm_ext_arbiter.sv | 148 ++++++++++++++
 tb/tb_imm_ext_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_arbiter_if.sv
// imm_ext_arbiter_if: request, response and extender-drive bundle for imm_ext_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/extender side.
interface imm_ext_arbiter_if #(
    parameter int unsigned IMM_W = 16
);
    logic [1:0]         i_req_valid;
    logic [IMM_W-1:0]   i_req_imm0;
    logic [IMM_W-1:0]   i_req_imm1;
    logic [1:0]         i_req_lui;
    logic [1:0]         i_req_signed;
    logic [1:0]         o_req_ready;
    logic [1:0]         o_rsp_valid;
    logic [2*IMM_W-1:0] o_rsp_data;
    logic [1:0]         i_rsp_ready;
    logic [IMM_W-1:0]   o_ext_in;
    logic               o_ext_LuiOp;
    logic               o_ext_SignedOp;
    logic [2*IMM_W-1:0] i_ext_out;
    logic               o_busy;

    modport slave (
        input  i_req_valid,
        input  i_req_imm0,
        input  i_req_imm1,
        input  i_req_lui,
        input  i_req_signed,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_data,
        input  i_rsp_ready,
        output o_ext_in,
        output o_ext_LuiOp,
        output o_ext_SignedOp,
        input  i_ext_out,
        output o_busy
    );

    modport master (
        output i_req_valid,
        output i_req_imm0,
        output i_req_imm1,
        output i_req_lui,
        output i_req_signed,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_data,
        output i_rsp_ready,
        input  o_ext_in,
        input  o_ext_LuiOp,
        input  o_ext_SignedOp,
        output i_ext_out,
        input  o_busy
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: shares one combinational immediate extender between two requesters.
// IDLE accepts one request, EXT drives the extender from the latched fields and captures
// its result, RESP holds the result for the owning requester until it is accepted.
// Build option: define IMM_ARB_ROUND_ROBIN_EN for round-robin arbitration when both
// requesters are valid; otherwise requester 0 has fixed priority.
module imm_ext_arbiter #(
    parameter int unsigned IMM_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    imm_ext_arbiter_if.slave arb
);
    localparam int unsigned EXT_W = 2 * IMM_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExt  = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             lui_q, lui_d;
    logic             signed_q, signed_d;
    logic             owner_q, owner_d;
    logic [EXT_W-1:0] rsp_data_q, rsp_data_d;

    logic             win;
    logic             accept;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [IMM_W-1:0] ext_in;
    logic             ext_lui;
    logic             ext_signed;

`ifdef IMM_ARB_ROUND_ROBIN_EN
    // Last granted requester; resets to 1 so requester 0 wins the first contention.
    logic last_q, last_d;
`endif

    // Pick the winner among the valid requesters.
    always_comb begin
        win = 1'b0;
        case (arb.i_req_valid)
            2'b10:   win = 1'b1;
`ifdef IMM_ARB_ROUND_ROBIN_EN
            2'b11:   win = ~last_q;
`endif
            default: win = 1'b0;
        endcase
    end

    assign accept = (state_q == StIdle) && (arb.i_req_valid != 2'b00);

`ifdef IMM_ARB_ROUND_ROBIN_EN
    // Pointer moves only when a request is actually accepted.
    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = win;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Next-state logic and combinational outputs for the IDLE/EXT/RESP sequence.
    always_comb begin
        state_d    = state_q;
        imm_d      = imm_q;
        lui_d      = lui_q;
        signed_d   = signed_q;
        owner_d    = owner_q;
        rsp_data_d = rsp_data_q;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        ext_in     = '0;
        ext_lui    = 1'b0;
        ext_signed = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_ready[win] = 1'b1;
                    imm_d          = win ? arb.i_req_imm1 : arb.i_req_imm0;
                    lui_d          = arb.i_req_lui[win];
                    signed_d       = arb.i_req_signed[win];
                    owner_d        = win;
                    state_d        = StExt;
                end
            end
            StExt: begin
                ext_in     = imm_q;
                ext_lui    = lui_q;
                ext_signed = signed_q;
                rsp_data_d = arb.i_ext_out;
                state_d    = StResp;
            end
            StResp: begin
                rsp_valid[owner_q] = 1'b1;
                // Only the owner's accept completes the response.
                if (arb.i_rsp_ready[owner_q]) begin
                    rsp_data_d = '0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            imm_q      <= '0;
            lui_q      <= 1'b0;
            signed_q   <= 1'b0;
            owner_q    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            imm_q      <= imm_d;
            lui_q      <= lui_d;
            signed_q   <= signed_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign arb.o_req_ready    = req_ready;
    assign arb.o_rsp_valid    = rsp_valid;
    // Data is gated so it reads zero whenever no response is valid.
    assign arb.o_rsp_data     = (state_q == StResp) ? rsp_data_q : '0;
    assign arb.o_ext_in       = ext_in;
    assign arb.o_ext_LuiOp    = ext_lui;
    assign arb.o_ext_SignedOp = ext_signed;
    assign arb.o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: scoreboard bench for imm_ext_arbiter. The stimulus process pushes
// the expected extension for every accepted request; a monitor process runs a
// transaction-level model of arbitration and timing and checks every cycle.
`timescale 1ns/1ps
module tb_imm_ext_arbiter;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned EXT_W = 2 * IMM_W;

    typedef struct {
        int               owner;
        logic [IMM_W-1:0] imm;
        logic             lui;
        logic             sgn;
        logic [EXT_W-1:0] data;
    } exp_t;

    logic   i_clk;
    logic   i_rst_n;
    exp_t   sb[$];
    int     grant_log[$];
    int     rd_idx;
    int     n_tests = 0;
    int     n_fail  = 0;

    imm_ext_arbiter_if #(.IMM_W(IMM_W)) arb ();

    imm_ext_arbiter #(.IMM_W(IMM_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .arb     (arb)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Behavioural extender: LuiOp shifts up, SignedOp sign-extends, else zero-extends.
    function automatic logic [EXT_W-1:0] ext_ref(input logic [IMM_W-1:0] imm,
                                                 input logic lui, input logic sgn);
        if (lui) return {imm, {IMM_W{1'b0}}};
        if (sgn) return {{IMM_W{imm[IMM_W-1]}}, imm};
        return {{IMM_W{1'b0}}, imm};
    endfunction

    assign arb.i_ext_out = ext_ref(arb.o_ext_in, arb.o_ext_LuiOp, arb.o_ext_SignedOp);

    // Arbitration rule: a lone requester wins; on contention the build decides.
    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef IMM_ARB_ROUND_ROBIN_EN
        return (last == 1) ? 0 : 1;
`else
        return (last < 0) ? 1 : 0;
`endif
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- monitor / reference model ----------------
    initial begin : monitor
        int         m_last;
        bit         m_idle;
        int         m_wait;
        int         m_owner;
        int         w;
        logic [1:0] exp_ready;
        exp_t       e;
        m_last  = 1;
        m_idle  = 1'b1;
        m_wait  = 0;
        m_owner = 0;
        rd_idx  = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                m_idle = 1'b1;
                m_last = 1;
                m_wait = 0;
                rd_idx = sb.size();
            end else begin
                check("busy", 64'(arb.o_busy), 64'(!m_idle));
                exp_ready = 2'b00;
                w = 0;
                if (m_idle && arb.i_req_valid != 2'b00) begin
                    w = pick(arb.i_req_valid, m_last);
                    exp_ready[w] = 1'b1;
                end
                check("req_ready", 64'(arb.o_req_ready), 64'(exp_ready));
                if (!m_idle && rd_idx >= sb.size()) begin
                    check("sb_entry_present", 64'(rd_idx), 64'(sb.size()));
                end else if (!m_idle && m_wait > 0) begin
                    e = sb[rd_idx];
                    check("ext_in", 64'(arb.o_ext_in), 64'(e.imm));
                    check("ext_lui", 64'(arb.o_ext_LuiOp), 64'(e.lui));
                    check("ext_signed", 64'(arb.o_ext_SignedOp), 64'(e.sgn));
                    check("rsp_valid_ext", 64'(arb.o_rsp_valid), 64'(0));
                    check("rsp_data_ext", 64'(arb.o_rsp_data), 64'(0));
                end else if (!m_idle) begin
                    e = sb[rd_idx];
                    check("rsp_valid", 64'(arb.o_rsp_valid), 64'(2'b01 << m_owner));
                    check("rsp_data", 64'(arb.o_rsp_data), 64'(e.data));
                    check("ext_in_resp", 64'(arb.o_ext_in), 64'(0));
                end else begin
                    check("rsp_valid_idle", 64'(arb.o_rsp_valid), 64'(0));
                    check("rsp_data_idle", 64'(arb.o_rsp_data), 64'(0));
                    check("ext_drive_idle",
                          64'({arb.o_ext_in, arb.o_ext_LuiOp, arb.o_ext_SignedOp}), 64'(0));
                end
                if (m_idle) begin
                    if (exp_ready != 2'b00) begin
                        m_idle  = 1'b0;
                        m_wait  = 1;
                        m_owner = w;
                        m_last  = w;
                    end
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (arb.i_rsp_ready[m_owner]) begin
                    m_idle = 1'b1;
                    rd_idx++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int k, input logic [IMM_W-1:0] imm, input logic lui,
                           input logic sgn);
        if (k == 0) arb.i_req_imm0 = imm;
        else        arb.i_req_imm1 = imm;
        arb.i_req_lui[k]    = lui;
        arb.i_req_signed[k] = sgn;
        arb.i_req_valid[k]  = 1'b1;
    endtask

    task automatic new_req(input int k);
        set_req(k, IMM_W'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    endtask

    // One cycle: record acceptances at the negedge, update requesters after the posedge.
    task automatic tick(input int new_pct, input bit refill);
        logic [1:0] acc;
        exp_t       e;
        @(negedge i_clk);
        acc = arb.i_req_valid & arb.o_req_ready;
        if (!i_rst_n) acc = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                e.owner = k;
                e.imm   = (k == 0) ? arb.i_req_imm0 : arb.i_req_imm1;
                e.lui   = arb.i_req_lui[k];
                e.sgn   = arb.i_req_signed[k];
                e.data  = ext_ref(e.imm, e.lui, e.sgn);
                sb.push_back(e);
                grant_log.push_back(k);
            end
        end
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) arb.i_req_valid[k] = 1'b0;
            if (!arb.i_req_valid[k] && i_rst_n &&
                ((refill && acc[k]) || $urandom_range(0, 99) < new_pct)) begin
                new_req(k);
            end
        end
    endtask

    task automatic do_reset();
        i_rst_n          = 1'b0;
        arb.i_req_valid  = 2'b00;
        arb.i_req_imm0   = '0;
        arb.i_req_imm1   = '0;
        arb.i_req_lui    = 2'b00;
        arb.i_req_signed = 2'b00;
        arb.i_rsp_ready  = 2'b00;
        tick(0, 1'b0);
        i_rst_n = 1'b1;
    endtask

    // Single request from idle with explicit latency and value checks.
    task automatic directed(input int k, input logic [IMM_W-1:0] imm, input logic lui,
                            input logic sgn, input logic [EXT_W-1:0] exp_data,
                            input string tag);
        logic [1:0] oh;
        oh = (k == 0) ? 2'b01 : 2'b10;
        set_req(k, imm, lui, sgn);
        arb.i_rsp_ready = 2'b00;
        #2 check({tag, "_ready_T"}, 64'(arb.o_req_ready), 64'(oh));
        tick(0, 1'b0);
        #2 check({tag, "_rsp_valid_T1"}, 64'(arb.o_rsp_valid), 64'(0));
        tick(0, 1'b0);
        arb.i_rsp_ready = oh;
        #2 check({tag, "_rsp_valid_T2"}, 64'(arb.o_rsp_valid), 64'(oh));
        check({tag, "_rsp_data_T2"}, 64'(arb.o_rsp_data), 64'(exp_data));
        tick(0, 1'b0);
        arb.i_rsp_ready = 2'b00;
        #2 check({tag, "_rsp_valid_done"}, 64'(arb.o_rsp_valid), 64'(0));
        check({tag, "_busy_done"}, 64'(arb.o_busy), 64'(0));
        tick(0, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int exp_order[4];
`ifdef IMM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        i_rst_n          = 1'b1;
        arb.i_req_valid  = 2'b00;
        arb.i_req_imm0   = '0;
        arb.i_req_imm1   = '0;
        arb.i_req_lui    = 2'b00;
        arb.i_req_signed = 2'b00;
        arb.i_rsp_ready  = 2'b00;
        #2;
        do_reset();
        #2 check("reset_busy", 64'(arb.o_busy), 64'(0));
        check("reset_rsp_valid", 64'(arb.o_rsp_valid), 64'(0));
        tick(0, 1'b0);

        // Directed extension cases.
        directed(0, 16'h8001, 1'b0, 1'b1, 32'hFFFF8001, "req0_signed");
        directed(1, 16'h1234, 1'b1, 1'b0, 32'h12340000, "req1_lui");
        directed(1, 16'h8001, 1'b0, 1'b0, 32'h00008001, "req1_zero");

        // Grant order under continuous contention, starting from reset.
        do_reset();
        grant_log.delete();
        new_req(0);
        new_req(1);
        arb.i_rsp_ready = 2'b11;
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) tick(0, 1'b1);
        check("grant_count", 64'(grant_log.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
        end
        for (int i = 0; i < 15; i++) tick(0, 1'b0);

        // Owner stalls the response; non-owner accept pulses must be ignored.
        do_reset();
        set_req(0, 16'hC3A5, 1'b0, 1'b1);
        set_req(1, 16'h0042, 1'b0, 1'b0);
        arb.i_rsp_ready = 2'b00;
        #2 check("stall_ready_T", 64'(arb.o_req_ready), 64'(2'b01));
        tick(0, 1'b0);
        tick(0, 1'b0);
        #2 check("stall_valid_T2", 64'(arb.o_rsp_valid), 64'(2'b01));
        for (int i = 0; i < 5; i++) begin
            tick(0, 1'b0);
            arb.i_rsp_ready = (i % 2 == 0) ? 2'b10 : 2'b00;
            #2 check("stall_valid", 64'(arb.o_rsp_valid), 64'(2'b01));
            check("stall_data", 64'(arb.o_rsp_data), 64'(32'hFFFFC3A5));
            check("stall_req_ready", 64'(arb.o_req_ready), 64'(0));
        end
        tick(0, 1'b0);
        arb.i_rsp_ready = 2'b01;
        #2 check("stall_valid_last", 64'(arb.o_rsp_valid), 64'(2'b01));
        tick(0, 1'b0);
        arb.i_rsp_ready = 2'b00;
        #2 check("stall_release_valid", 64'(arb.o_rsp_valid), 64'(0));
        check("stall_req1_granted", 64'(arb.o_req_ready), 64'(2'b10));
        arb.i_rsp_ready = 2'b11;
        for (int i = 0; i < 8; i++) tick(0, 1'b0);

        // Asynchronous reset in the middle of RESP.
        do_reset();
        set_req(0, 16'h7FFF, 1'b0, 1'b1);
        arb.i_rsp_ready = 2'b00;
        tick(0, 1'b0);
        tick(0, 1'b0);
        #2 check("rst_pre_valid", 64'(arb.o_rsp_valid), 64'(2'b01));
        i_rst_n = 1'b0;
        #1 check("rst_rsp_valid", 64'(arb.o_rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(arb.o_rsp_data), 64'(0));
        check("rst_busy", 64'(arb.o_busy), 64'(0));
        check("rst_req_ready", 64'(arb.o_req_ready), 64'(0));
        check("rst_ext_drive",
              64'({arb.o_ext_in, arb.o_ext_LuiOp, arb.o_ext_SignedOp}), 64'(0));
        tick(0, 1'b0);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1'b0);
            #2 check("post_rst_valid", 64'(arb.o_rsp_valid), 64'(0));
            check("post_rst_busy", 64'(arb.o_busy), 64'(0));
        end

        // Random traffic with random response back-pressure.
        for (int i = 0; i < 800; i++) begin
            tick(30, 1'b0);
            arb.i_rsp_ready = 2'($urandom);
        end
        arb.i_rsp_ready = 2'b11;
        for (int i = 0; i < 20; i++) tick(0, 1'b0);
        check("sb_drained", 64'(rd_idx), 64'(sb.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
